// File: rtl/xdma_pkg.sv
// Shared types and AXI encodings for the XDMA write receiver.
package xdma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } xdma_wrx_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

endpackage

// File: rtl/xdma_write_receiver_if.sv
// AXI4 write-channel bundle (AW/W/B) between the remote XDMA backend and the receiver.
interface xdma_write_receiver_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [IdWidth-1:0]   aw_id;
  logic [AddrWidth-1:0] aw_addr;
  logic [7:0]           aw_len;
  logic [2:0]           aw_size;
  logic [1:0]           aw_burst;
  logic                 aw_valid;
  logic                 aw_ready;

  logic [DataWidth-1:0] w_data;
  logic [StrbWidth-1:0] w_strb;
  logic                 w_last;
  logic                 w_valid;
  logic                 w_ready;

  logic [IdWidth-1:0]   b_id;
  logic [1:0]           b_resp;
  logic                 b_valid;
  logic                 b_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/xdma_write_receiver_fifo_v3.sv
// Generic FIFO (fifo_v3 drop-in); optional fall-through bypass when empty.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       rd_q, wr_q;
  logic [PtrW:0]         cnt_q;
  logic                  mem_empty, do_push, do_pop;

  assign full_o    = (cnt_q == (PtrW + 1)'(DEPTH));
  assign mem_empty = (cnt_q == '0);
  assign empty_o   = FALL_THROUGH ? (mem_empty && !push_i) : mem_empty;
  assign data_o    = (FALL_THROUGH && mem_empty) ? data_i : mem_q[rd_q];
  // A bypassed push+pop on an empty FIFO never touches storage.
  assign do_push   = push_i && !full_o && !(FALL_THROUGH && mem_empty && pop_i);
  assign do_pop    = pop_i && !mem_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == LastPtr) ? '0 : wr_q + PtrW'(1);
      if (do_pop)  rd_q <= (rd_q == LastPtr) ? '0 : rd_q + PtrW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (PtrW + 1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/xdma_write_receiver.sv
// AXI4 write responder: buffers AW descriptors, splits bursts into addressed local beats, returns one B per burst.
module xdma_write_receiver
  import xdma_pkg::*;
#(
  parameter int unsigned AwFifoDepth = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned IdWidth     = 4,
  localparam int unsigned StrbWidth  = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  xdma_write_receiver_if.slave axi_dma,
  output logic [AddrWidth-1:0] write_addr_o,
  output logic [DataWidth-1:0] write_data_o,
  output logic [StrbWidth-1:0] write_strb_o,
  output logic                 write_last_o,
  output logic                 write_valid_o,
  input  logic                 write_ready_i,
  output logic                 busy_o
);
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } xdma_wrx_aw_desc_t;

  xdma_wrx_aw_desc_t    aw_desc, fifo_desc;
  xdma_wrx_state_e      state_q;
  logic [IdWidth-1:0]   cur_id_q;
  logic [AddrWidth-1:0] cur_addr_q;
  logic [7:0]           cur_len_q;
  logic [2:0]           cur_size_q;
  logic [8:0]           beat_cnt_q;
  logic                 err_q, drop_q, b_valid_q;
  logic                 fifo_full, fifo_empty, fifo_pop, w_hs, is_last;
  logic [AddrWidth-1:0] size_bytes, next_addr;

  assign aw_desc = '{id:    axi_dma.aw_id,
                     addr:  axi_dma.aw_addr,
                     len:   axi_dma.aw_len,
                     size:  axi_dma.aw_size,
                     burst: axi_dma.aw_burst};

  assign axi_dma.aw_ready = !fifo_full;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   ($bits(xdma_wrx_aw_desc_t)),
    .DEPTH        (AwFifoDepth)
  ) i_aw_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (aw_desc),
    .push_i  (axi_dma.aw_valid && !fifo_full),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (fifo_desc),
    .pop_i   (fifo_pop)
  );

  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign is_last    = (beat_cnt_q == {1'b0, cur_len_q});
  assign size_bytes = AddrWidth'(1) << cur_size_q;
  assign next_addr  = (cur_addr_q & ~(size_bytes - AddrWidth'(1))) + size_bytes;

  // Bursts flagged bad at start are drained locally; w_ready must not wait on the consumer.
  assign axi_dma.w_ready = (state_q == DATA) && (drop_q || write_ready_i);
  assign w_hs            = axi_dma.w_valid && axi_dma.w_ready;

  assign write_valid_o = (state_q == DATA) && !drop_q && axi_dma.w_valid;
  assign write_last_o  = (state_q == DATA) && is_last;
  assign write_addr_o  = cur_addr_q;
  assign write_data_o  = axi_dma.w_data;
  assign write_strb_o  = axi_dma.w_strb;
  assign busy_o        = (state_q != IDLE) || !fifo_empty;

  assign axi_dma.b_valid = b_valid_q;
  assign axi_dma.b_id    = cur_id_q;
  assign axi_dma.b_resp  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      cur_addr_q <= '0;
      cur_len_q  <= '0;
      cur_size_q <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_id_q   <= fifo_desc.id;
            cur_addr_q <= fifo_desc.addr;
            cur_len_q  <= fifo_desc.len;
            cur_size_q <= fifo_desc.size;
            beat_cnt_q <= '0;
            err_q      <= (fifo_desc.burst != AXI_BURST_INCR);
            drop_q     <= (fifo_desc.burst != AXI_BURST_INCR);
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            cur_addr_q <= next_addr;
            if (axi_dma.w_last != is_last) err_q <= 1'b1;
            if (is_last) begin
              state_q   <= RESP;
              b_valid_q <= 1'b1;
            end
          end
        end
        RESP: begin
          if (axi_dma.b_ready) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xdma_write_receiver.sv
// Scoreboard bench for xdma_write_receiver: directed bursts, queued expectations, negedge monitor.
module tb_xdma_write_receiver;
  localparam int unsigned Budget = 200;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] write_addr;
  logic [63:0] write_data;
  logic [7:0]  write_strb;
  logic        write_last, write_valid, busy;
  logic        write_ready = 1'b0;
  int          rdy_mode = 0;  // 0: ready high, 1: toggle, 2: stalled

  beat_t  exp_beats[$];
  bresp_t exp_b[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     last_w_cyc = 0;
  logic   saw_aw_stall = 1'b0;

  xdma_write_receiver_if #(.AddrWidth(32), .DataWidth(64), .IdWidth(4)) axi_if ();

  xdma_write_receiver #(
    .AwFifoDepth (2),
    .AddrWidth   (32),
    .DataWidth   (64),
    .IdWidth     (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .axi_dma       (axi_if),
    .write_addr_o  (write_addr),
    .write_data_o  (write_data),
    .write_strb_o  (write_strb),
    .write_last_o  (write_last),
    .write_valid_o (write_valid),
    .write_ready_i (write_ready),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       write_ready = 1'b1;
      1:       write_ready = ~write_ready;
      default: write_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: handshakes complete at the following posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi_if.aw_valid && !axi_if.aw_ready) saw_aw_stall = 1'b1;
      if (axi_if.w_valid && axi_if.w_ready) last_w_cyc = cyc;
      if (write_valid && write_ready) begin
        if (exp_beats.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else begin
          beat_t e;
          e = exp_beats.pop_front();
          check("beat_addr", 64'(write_addr), 64'(e.addr));
          check("beat_data", write_data, e.data);
          check("beat_strb", 64'(write_strb), 64'(e.strb));
          check("beat_last", 64'(write_last), 64'(e.last));
        end
      end
      if (axi_if.b_valid && axi_if.b_ready) begin
        if (exp_b.size() == 0) check("unexpected_b", 64'd1, 64'd0);
        else begin
          bresp_t e;
          e = exp_b.pop_front();
          check("b_id", 64'(axi_if.b_id), 64'(e.id));
          check("b_resp", 64'(axi_if.b_resp), 64'(e.resp));
          check("b_latency", 64'(cyc), 64'(last_w_cyc + 1));
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_write_valid", 64'(write_valid), 64'd0);
    check("rst_write_last", 64'(write_last), 64'd0);
    check("rst_write_addr", 64'(write_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_aw_ready", 64'(axi_if.aw_ready), 64'd1);
    check("rst_w_ready", 64'(axi_if.w_ready), 64'd0);
    check("rst_b_valid", 64'(axi_if.b_valid), 64'd0);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int unsigned t = 0;
    logic rdy;
    axi_if.aw_id = id; axi_if.aw_addr = addr; axi_if.aw_len = len;
    axi_if.aw_size = size; axi_if.aw_burst = burst; axi_if.aw_valid = 1'b1;
    do begin
      @(negedge clk); rdy = axi_if.aw_ready;
      @(posedge clk); #1; t++;
    end while (!rdy && t < Budget);
    if (!rdy) check("aw_timeout", 64'(rdy), 64'd1);
    axi_if.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                        input logic drop, input logic mirror);
    int unsigned t = 0;
    logic rdy;
    axi_if.w_data = data; axi_if.w_strb = strb; axi_if.w_last = last; axi_if.w_valid = 1'b1;
    do begin
      @(negedge clk); rdy = axi_if.w_ready;
      if (drop) check("drop_no_valid", 64'(write_valid), 64'd0);
      if (mirror) check("w_ready_mirror", 64'(axi_if.w_ready), 64'(write_ready));
      @(posedge clk); #1; t++;
    end while (!rdy && t < Budget);
    if (!rdy) check("w_timeout", 64'(rdy), 64'd1);
    axi_if.w_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned t = 0;
    while ((exp_beats.size() != 0 || exp_b.size() != 0 || busy) && t < Budget) begin
      @(posedge clk); #1; t++;
    end
    check("drain_beats", 64'(exp_beats.size()), 64'd0);
    check("drain_b", 64'(exp_b.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_if.aw_valid = 1'b0; axi_if.w_valid = 1'b0; axi_if.b_ready = 1'b1;
    axi_if.aw_id = '0; axi_if.aw_addr = '0; axi_if.aw_len = '0; axi_if.aw_size = '0; axi_if.aw_burst = '0;
    axi_if.w_data = '0; axi_if.w_strb = '0; axi_if.w_last = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;

    // Single beat, len=0
    exp_beats.push_back('{32'h1000, 64'hA5A5_0000_0000_0001, 8'hFF, 1'b1});
    exp_b.push_back('{4'd5, 2'b00});
    send_aw(4'd5, 32'h1000, 8'd0, 3'd3, 2'b01);
    send_w(64'hA5A5_0000_0000_0001, 8'hFF, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Unaligned start, len=3, size=3
    exp_beats.push_back('{32'h1004, 64'h1111_0000_0000_0000, 8'hF0, 1'b0});
    exp_beats.push_back('{32'h1008, 64'h1111_0000_0000_0001, 8'hFF, 1'b0});
    exp_beats.push_back('{32'h1010, 64'h1111_0000_0000_0002, 8'hFF, 1'b0});
    exp_beats.push_back('{32'h1018, 64'h1111_0000_0000_0003, 8'h0F, 1'b1});
    exp_b.push_back('{4'd2, 2'b00});
    send_aw(4'd2, 32'h1004, 8'd3, 3'd3, 2'b01);
    send_w(64'h1111_0000_0000_0000, 8'hF0, 1'b0, 1'b0, 1'b0);
    send_w(64'h1111_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_w(64'h1111_0000_0000_0002, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_w(64'h1111_0000_0000_0003, 8'h0F, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Backpressure, len=7, size=2
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      exp_beats.push_back('{32'h2000 + 32'(4 * i), 64'hB0B0_0000_0000_0000 + 64'(i),
                            8'h80 | 8'(i), (i == 7)});
    exp_b.push_back('{4'd11, 2'b00});
    send_aw(4'd11, 32'h2000, 8'd7, 3'd2, 2'b01);
    for (int i = 0; i < 8; i++)
      send_w(64'hB0B0_0000_0000_0000 + 64'(i), 8'h80 | 8'(i), (i == 7), 1'b0, (i > 0));
    rdy_mode = 0;
    wait_drain();

    // FIXED burst: beats absorbed, SLVERR
    exp_b.push_back('{4'd7, 2'b10});
    send_aw(4'd7, 32'h7000, 8'd1, 3'd3, 2'b00);
    send_w(64'hDEAD_0000_0000_0000, 8'hFF, 1'b0, 1'b1, 1'b0);
    send_w(64'hDEAD_0000_0000_0001, 8'hFF, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Early w.last on beat 2 of len=2: all beats forwarded, SLVERR
    exp_beats.push_back('{32'h4000, 64'hC0C0_0000_0000_0000, 8'hFF, 1'b0});
    exp_beats.push_back('{32'h4008, 64'hC0C0_0000_0000_0001, 8'hFF, 1'b0});
    exp_beats.push_back('{32'h4010, 64'hC0C0_0000_0000_0002, 8'hFF, 1'b1});
    exp_b.push_back('{4'd9, 2'b10});
    send_aw(4'd9, 32'h4000, 8'd2, 3'd3, 2'b01);
    send_w(64'hC0C0_0000_0000_0000, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_w(64'hC0C0_0000_0000_0001, 8'hFF, 1'b1, 1'b0, 1'b0);
    send_w(64'hC0C0_0000_0000_0002, 8'hFF, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // AW buffer fills while W is stalled; B order follows AW order
    rdy_mode = 2;
    saw_aw_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_beats.push_back('{32'h3000 + 32'(i * 256), 64'hE000_0000_0000_0000 + 64'(2 * i), 8'hFF, 1'b0});
      exp_beats.push_back('{32'h3008 + 32'(i * 256), 64'hE000_0000_0000_0001 + 64'(2 * i), 8'hFF, 1'b1});
      exp_b.push_back('{4'(i + 1), 2'b00});
    end
    fork
      begin
        for (int i = 0; i < 4; i++) send_aw(4'(i + 1), 32'h3000 + 32'(i * 256), 8'd1, 3'd3, 2'b01);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        check("aw_backpressure", 64'(saw_aw_stall), 64'd1);
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
          send_w(64'hE000_0000_0000_0000 + 64'(2 * i), 8'hFF, 1'b0, 1'b0, 1'b0);
          send_w(64'hE000_0000_0000_0001 + 64'(2 * i), 8'hFF, 1'b1, 1'b0, 1'b0);
        end
      end
    join
    wait_drain();

    // Reset during beat 2 of len=3: no B, outputs back to reset values
    exp_beats.push_back('{32'h5000, 64'hF000_0000_0000_0000, 8'hFF, 1'b0});
    send_aw(4'd3, 32'h5000, 8'd3, 3'd3, 2'b01);
    send_w(64'hF000_0000_0000_0000, 8'hFF, 1'b0, 1'b0, 1'b0);
    axi_if.w_data = 64'hF000_0000_0000_0001; axi_if.w_strb = 8'hFF;
    axi_if.w_last = 1'b0; axi_if.w_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    axi_if.w_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_beats.push_back('{32'h6000, 64'h6666_0000_0000_0000, 8'h3C, 1'b1});
    exp_b.push_back('{4'd6, 2'b00});
    send_aw(4'd6, 32'h6000, 8'd0, 3'd3, 2'b01);
    send_w(64'h6666_0000_0000_0000, 8'h3C, 1'b1, 1'b0, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
